lzs_code_emit: RTL and testbench

//  Encoder-side LZS code emitter: converts literal/match/end tokens from the match finder into

---
 rtl/lzs_pkg.sv | 69 ++++++
 rtl/lzs_len_code.sv | 37 +++
 rtl/lzs_code_emit.sv | 153 +++++++++++++++
 tb/tb_lzs_code_emit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lzs_pkg.sv
// Shared definitions for the LZS encoder-side code emitter: FSM states,
// code field prefixes, length-field constants and field builder helpers.
package lzs_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LIT  = 3'd1,
        S_OFF  = 3'd2,
        S_LEN  = 3'd3,
        S_EXT  = 3'd4,
        S_END  = 3'd5
    } state_t;

    localparam int CODE_W = 13;
    localparam int WID_W  = 4;

    localparam logic       LIT_PFX   = 1'b0;
    localparam logic [1:0] OFF7_PFX  = 2'b11;
    localparam logic [1:0] OFF11_PFX = 2'b10;
    localparam logic [8:0] END_CODE  = 9'b110000000;
    localparam int         OFF7_MAX  = 127;

    // Length field: short lengths 2..4 use a 2-bit code, 5..7 a 4-bit code,
    // 8 and above the escape nibble followed by extension nibbles of 15 each.
    localparam logic [3:0] LEN_ESC       = 4'b1111;
    localparam int         LEN_MID_MIN   = 5;
    localparam int         LEN_LONG_MIN  = 8;
    localparam int         LEN_EXT_STEP  = 15;

    // One MSB-aligned code field with its valid bit count.
    typedef struct packed {
        logic [CODE_W-1:0] data;
        logic [WID_W-1:0]  width;
    } code_t;

    function automatic code_t lit_code(input logic [7:0] lit);
        code_t c;
        c.data  = {LIT_PFX, lit, 4'b0000};
        c.width = 4'd9;
        return c;
    endfunction

    function automatic code_t off_code(input logic [10:0] off);
        code_t c;
        if (off <= 11'(OFF7_MAX)) begin
            c.data  = {OFF7_PFX, off[6:0], 4'b0000};
            c.width = 4'd9;
        end else begin
            c.data  = {OFF11_PFX, off};
            c.width = 4'd13;
        end
        return c;
    endfunction

    function automatic code_t end_code();
        code_t c;
        c.data  = {END_CODE, 4'b0000};
        c.width = 4'd9;
        return c;
    endfunction

    function automatic code_t nibble_code(input logic [3:0] v);
        code_t c;
        c.data  = {v, 9'b0};
        c.width = 4'd4;
        return c;
    endfunction

endpackage

// File: rtl/lzs_len_code.sv
// Combinational length encoder: maps a match length to its leading length
// field and, for long matches, the remainder left for extension nibbles.
module lzs_len_code
    import lzs_pkg::*;
#(
    parameter int LEN_W = 12
) (
    input  logic [LEN_W-1:0] i_len,
    output code_t            o_code,
    output logic             o_long,
    output logic [LEN_W-1:0] o_rem
);

    // Select the length field; lengths below 2 are illegal and coded as 2.
    always_comb begin
        o_code = '0;
        o_long = 1'b0;
        o_rem  = '0;
        if (i_len <= LEN_W'(2)) begin
            o_code.data  = {2'b00, 11'b0};
            o_code.width = 4'd2;
        end else if (i_len == LEN_W'(3)) begin
            o_code.data  = {2'b01, 11'b0};
            o_code.width = 4'd2;
        end else if (i_len == LEN_W'(4)) begin
            o_code.data  = {2'b10, 11'b0};
            o_code.width = 4'd2;
        end else if (i_len < LEN_W'(LEN_LONG_MIN)) begin
            o_code = nibble_code(4'd12 + 4'(i_len - LEN_W'(LEN_MID_MIN)));
        end else begin
            o_code = nibble_code(LEN_ESC);
            o_long = 1'b1;
            o_rem  = i_len - LEN_W'(LEN_LONG_MIN);
        end
    end

endmodule

// File: rtl/lzs_code_emit.sv
// LZS code emitter: accepts literal/match/end tokens and presents one
// MSB-aligned code field per beat to the bit packer, with a registered
// valid/ack output stage, extension-nibble counter and emitted-bit counter.
module lzs_code_emit
    import lzs_pkg::*;
#(
    parameter int LEN_W = 12,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tok_valid,
    output logic              tok_ack,
    input  logic              tok_match,
    input  logic              tok_end,
    input  logic [7:0]        tok_lit,
    input  logic [10:0]       tok_off,
    input  logic [LEN_W-1:0]  tok_len,
    output logic [CODE_W-1:0] code_data,
    output logic [WID_W-1:0]  code_width,
    output logic              code_valid,
    input  logic              code_ack,
    output logic              done,
    output logic              tok_err,
    output logic [CNT_W-1:0]  bit_count
);

    state_t           r_state;
    code_t            r_code;
    logic             r_valid;
    logic             r_done;
    logic             r_err;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_rem;
    logic [CNT_W-1:0] r_bits;

    code_t            w_len_code;
    logic             w_len_long;
    logic [LEN_W-1:0] w_len_rem;
    logic             w_xfer;
    logic             w_ext_more;
    logic [LEN_W-1:0] w_rem_next;

    // Extension nibble for a remaining length: escape while 15 or more is left.
    function automatic code_t ext_code(input logic [LEN_W-1:0] rem);
        return nibble_code((rem >= LEN_W'(LEN_EXT_STEP)) ? LEN_ESC : rem[3:0]);
    endfunction

    lzs_len_code #(.LEN_W(LEN_W)) u_len_code (
        .i_len  (r_len),
        .o_code (w_len_code),
        .o_long (w_len_long),
        .o_rem  (w_len_rem)
    );

    assign w_xfer     = r_valid & code_ack;
    assign w_ext_more = (r_rem >= LEN_W'(LEN_EXT_STEP));
    assign w_rem_next = r_rem - LEN_W'(LEN_EXT_STEP);

    assign tok_ack    = (r_state == S_IDLE) & tok_valid & ~rst;
    assign code_data  = r_code.data;
    assign code_width = r_code.width;
    assign code_valid = r_valid;
    assign done       = r_done;
    assign tok_err    = r_err;
    assign bit_count  = r_bits;

    // Field sequencer: the register always holds the field being presented;
    // on each transfer the next field of the token is loaded without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_len   <= '0;
            r_rem   <= '0;
            r_bits  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_xfer) begin
                r_bits <= r_bits + CNT_W'(r_code.width);
            end
            case (r_state)
                S_IDLE: begin
                    if (tok_valid) begin
                        r_len   <= tok_len;
                        r_valid <= 1'b1;
                        if (tok_end) begin
                            r_state <= S_END;
                            r_code  <= end_code();
                        end else if (tok_match) begin
                            r_state <= S_OFF;
                            r_code  <= off_code(tok_off);
                            if ((tok_off == 11'd0) || (tok_len < LEN_W'(2))) begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_state <= S_LIT;
                            r_code  <= lit_code(tok_lit);
                        end
                    end
                end
                S_OFF: begin
                    if (w_xfer) begin
                        r_state <= S_LEN;
                        r_code  <= w_len_code;
                        r_rem   <= w_len_rem;
                    end
                end
                S_LEN: begin
                    if (w_xfer) begin
                        if (w_len_long) begin
                            r_state <= S_EXT;
                            r_code  <= ext_code(r_rem);
                        end else begin
                            r_state <= S_IDLE;
                            r_code  <= '0;
                            r_valid <= 1'b0;
                        end
                    end
                end
                S_EXT: begin
                    if (w_xfer) begin
                        if (w_ext_more) begin
                            r_rem  <= w_rem_next;
                            r_code <= ext_code(w_rem_next);
                        end else begin
                            r_state <= S_IDLE;
                            r_code  <= '0;
                            r_valid <= 1'b0;
                        end
                    end
                end
                S_LIT, S_END: begin
                    if (w_xfer) begin
                        r_done  <= (r_state == S_END);
                        r_state <= S_IDLE;
                        r_code  <= '0;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_code  <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lzs_code_emit.sv
// Self-checking bench for lzs_code_emit: directed cases plus random tokens,
// each checked against a field-list model built from the LZS coding rules.
module tb_lzs_code_emit;

    localparam int LEN_W = 12;
    localparam int CNT_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              tok_valid;
    logic              tok_ack;
    logic              tok_match;
    logic              tok_end;
    logic [7:0]        tok_lit;
    logic [10:0]       tok_off;
    logic [LEN_W-1:0]  tok_len;
    logic [12:0]       code_data;
    logic [3:0]        code_width;
    logic              code_valid;
    logic              code_ack;
    logic              done;
    logic              tok_err;
    logic [CNT_W-1:0]  bit_count;

    int errors = 0;
    int checks = 0;

    logic [12:0]      exp_d[$];
    logic [3:0]       exp_w[$];
    logic [CNT_W-1:0] bits_model = '0;
    logic             err_model  = 1'b0;

    always #5 clk = ~clk;

    lzs_code_emit #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .tok_valid  (tok_valid),
        .tok_ack    (tok_ack),
        .tok_match  (tok_match),
        .tok_end    (tok_end),
        .tok_lit    (tok_lit),
        .tok_off    (tok_off),
        .tok_len    (tok_len),
        .code_data  (code_data),
        .code_width (code_width),
        .code_valid (code_valid),
        .code_ack   (code_ack),
        .done       (done),
        .tok_err    (tok_err),
        .bit_count  (bit_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Append a field given as a right-aligned value of w bits.
    task automatic push(input int val, input int w);
        exp_d.push_back(13'(val << (13 - w)));
        exp_w.push_back(4'(w));
    endtask

    // Expected field list for one token, straight from the coding rules.
    task automatic model(input bit e, input bit m, input logic [7:0] lit,
                         input logic [10:0] off, input int len);
        int l;
        int r;
        exp_d.delete();
        exp_w.delete();
        if (e) begin
            push(9'b110000000, 9);
        end else if (!m) begin
            push(int'(lit), 9);
        end else begin
            if (off < 128) push(('b11 << 7) + int'(off[6:0]), 9);
            else           push(('b10 << 11) + int'(off), 13);
            l = (len < 2) ? 2 : len;
            if (l <= 4) begin
                push(l - 2, 2);
            end else if (l <= 7) begin
                push(l - 5 + 12, 4);
            end else begin
                push(15, 4);
                r = l - 8;
                while (r >= 15) begin
                    push(15, 4);
                    r -= 15;
                end
                push(r, 4);
            end
        end
    endtask

    // Present one token, collect its fields and compare with the model.
    // stall: cycles with code_ack low after the first field (token held on tok_valid).
    // abort_at: stop collecting after this many transfers (0 = run to completion).
    task automatic send_token(input bit e, input bit m, input logic [7:0] lit,
                              input logic [10:0] off, input int len,
                              input int ack_pct, input int stall, input int abort_at);
        int n;
        int idx;
        int cyc;
        int nf;
        model(e, m, lit, off, len);
        nf = exp_d.size();
        tok_end   = e;
        tok_match = m;
        tok_lit   = lit;
        tok_off   = off;
        tok_len   = LEN_W'(len);
        tok_valid = 1'b1;
        #1;
        n = 0;
        while (tok_ack !== 1'b1 && n < 50) begin
            code_ack = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        chk("tok_ack_seen", tok_ack, 1);
        if (m && !e && (off == 0 || len < 2)) err_model = 1'b1;
        code_ack = 1'b0;
        step();
        chk("tok_ack_pulse", tok_ack, 0);
        tok_valid = 1'b0;
        chk("first_field_latency", code_valid, 1);
        idx = 0;
        cyc = 0;
        while (idx < nf && cyc < 2000) begin
            if (abort_at > 0 && idx == abort_at) break;
            if (stall > 0 && cyc == 0) begin
                code_ack = 1'b1;
            end else if (stall > 0 && cyc <= stall) begin
                code_ack  = 1'b0;
                tok_valid = 1'b1;
                tok_end   = 1'b0;
                tok_match = 1'b0;
                tok_lit   = 8'h5A;
            end else begin
                tok_valid = 1'b0;
                code_ack  = ($urandom_range(0, 99) < ack_pct);
            end
            #1;
            if (tok_valid) chk("held_tok_no_ack", tok_ack, 0);
            chk("code_valid", code_valid, 1);
            chk($sformatf("data[%0d]", idx), code_data, exp_d[idx]);
            chk($sformatf("width[%0d]", idx), code_width, exp_w[idx]);
            if (code_ack) begin
                bits_model += CNT_W'(exp_w[idx]);
                idx++;
            end
            step();
            cyc++;
        end
        code_ack  = 1'b0;
        tok_valid = 1'b0;
        if (abort_at > 0) return;
        chk("all_fields_seen", idx, nf);
        chk("idle_after_token", code_valid, 0);
        chk("done_pulse", done, e);
        chk("bit_count", bit_count, bits_model);
        chk("tok_err", tok_err, err_model);
        step();
        chk("done_cleared", done, 0);
        chk("still_idle", code_valid, 0);
        $display("token e=%0b m=%0b lit=%02h off=%0d len=%0d fields=%0d bit_count=%0d",
                 e, m, lit, off, len, nf, bit_count);
    endtask

    initial begin
        bit         e;
        bit         m;
        int         len;
        logic [10:0] off;
        logic [7:0] lit;

        rst = 1'b1; tok_valid = 1'b0; tok_match = 1'b0; tok_end = 1'b0;
        tok_lit = '0; tok_off = '0; tok_len = '0; code_ack = 1'b0;
        step();
        step();
        tok_valid = 1'b1;
        #1;
        chk("rst_tok_ack", tok_ack, 0);
        chk("rst_code_valid", code_valid, 0);
        chk("rst_code_data", code_data, 0);
        chk("rst_code_width", code_width, 0);
        chk("rst_done", done, 0);
        chk("rst_tok_err", tok_err, 0);
        chk("rst_bit_count", bit_count, 0);
        tok_valid = 1'b0;
        step();
        rst = 1'b0;
        step();

        send_token(0, 0, 8'h41, 11'd0, 0, 100, 0, 0);
        chk("lit41_bits", bit_count, 9);
        send_token(0, 1, 8'h00, 11'd5, 3, 100, 0, 0);
        chk("off5len3_bits", bit_count, 20);
        send_token(0, 1, 8'h00, 11'd1000, 7, 100, 0, 0);
        send_token(0, 1, 8'h00, 11'd2, 23, 100, 0, 0);
        send_token(0, 1, 8'h00, 11'd127, 8, 100, 0, 0);
        send_token(0, 1, 8'h00, 11'd128, 22, 100, 0, 0);
        send_token(0, 1, 8'h00, 11'd300, 10, 100, 5, 0);
        send_token(0, 1, 8'h00, 11'd2047, 4095, 70, 0, 0);
        send_token(1, 0, 8'h00, 11'd0, 0, 100, 0, 0);
        chk("tok_err_clean", tok_err, 0);
        send_token(0, 1, 8'h00, 11'd0, 1, 100, 0, 0);
        chk("tok_err_sticky", tok_err, 1);

        for (int t = 0; t < 30; t++) begin
            e   = ($urandom_range(0, 9) == 0);
            m   = ($urandom_range(0, 1) == 1);
            lit = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0)     off = 11'd0;
            else if ($urandom_range(0, 1) == 0) off = 11'($urandom_range(1, 127));
            else                                off = 11'($urandom_range(128, 2047));
            if ($urandom_range(0, 19) == 0)     len = $urandom_range(0, 1);
            else if ($urandom_range(0, 7) == 0) len = $urandom_range(41, 400);
            else                                len = $urandom_range(2, 40);
            send_token(e, m, lit, off, len, $urandom_range(40, 100), 0, 0);
        end

        // Reset while extension nibbles are being emitted.
        send_token(0, 1, 8'h00, 11'd9, 200, 100, 0, 3);
        rst = 1'b1;
        code_ack = 1'b1;
        step();
        chk("abort_code_valid", code_valid, 0);
        chk("abort_bit_count", bit_count, 0);
        chk("abort_tok_err", tok_err, 0);
        rst = 1'b0;
        bits_model = '0;
        err_model  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_no_fields", code_valid, 0);
        end
        code_ack = 1'b0;
        send_token(0, 0, 8'hC3, 11'd0, 0, 100, 0, 0);
        chk("post_abort_bits", bit_count, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
